imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_ctrl.sv | 108 ++++++++++
 tb/tb_imem_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
// Instruction memory controller: the host loader writes 32-bit words one byte per
// cycle, and it takes priority over core instruction fetches.
module imem_ctrl #(
  parameter int MEM_BYTES = 512,
  parameter int AW        = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_req,
  input  logic [AW-1:0]                fetch_addr,
  output logic                         fetch_grant,
  output logic                         fetch_err,
  output logic [AW-1:0]                im_addr,
  output logic                         core_hold,
  input  logic                         ld_valid,
  input  logic [$clog2(MEM_BYTES)-1:0] ld_addr,
  input  logic [31:0]                  ld_data,
  output logic                         ld_ready,
  output logic                         ld_done,
  output logic                         ld_err,
  output logic                         mem_we,
  output logic [$clog2(MEM_BYTES)-1:0] mem_waddr,
  output logic [7:0]                   mem_wdata,
  output logic [9:0]                   words_loaded
);

  localparam int LW = $clog2(MEM_BYTES);
  localparam logic [LW-1:0] LD_LAST = LW'(MEM_BYTES - 4);
  localparam logic [AW-1:0] FE_LAST = AW'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_k;
  logic [LW-1:0]   r_addr;
  logic [31:0]     r_data;
  logic            r_ld_err;
  logic [9:0]      r_words;
  logic [AW-1:0]   r_im_addr;

  logic            w_ld_bad;
  logic            w_fetch_bad;
  logic [AW-1:0]   w_im_next;

  assign w_ld_bad    = (ld_addr[1:0] != 2'b00) || (ld_addr > LD_LAST);
  assign w_fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr > FE_LAST);

  // The loader owns the memory as soon as it offers a word, even before acceptance.
  assign core_hold   = (r_state != IDLE) || ld_valid;
  assign fetch_grant = fetch_req && !core_hold;
  assign fetch_err   = fetch_grant && w_fetch_bad;
  assign w_im_next   = w_fetch_bad ? '0 : fetch_addr;
  assign im_addr     = fetch_grant ? w_im_next : r_im_addr;

  assign ld_ready     = (r_state == IDLE);
  assign ld_done      = (r_state == DONE);
  assign ld_err       = r_ld_err;
  assign words_loaded = r_words;

  assign mem_we    = (r_state == WRITE);
  assign mem_waddr = mem_we ? (r_addr + LW'(r_k)) : '0;
  assign mem_wdata = mem_we ? r_data[8*r_k +: 8] : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_k       <= 2'd0;
      r_addr    <= '0;
      r_data    <= 32'h0;
      r_ld_err  <= 1'b0;
      r_words   <= 10'd0;
      r_im_addr <= '0;
    end else begin
      r_ld_err <= 1'b0;
      if (fetch_grant) begin
        r_im_addr <= w_im_next;
      end
      case (r_state)
        IDLE: begin
          if (ld_valid) begin
            if (w_ld_bad) begin
              r_ld_err <= 1'b1;
            end else begin
              r_state <= WRITE;
              r_k     <= 2'd0;
              r_addr  <= ld_addr;
              r_data  <= ld_data;
            end
          end
        end
        WRITE: begin
          r_k <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          if (r_words != 10'h3FF) begin
            r_words <= r_words + 10'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: word loads, rejected loads, fetch arbitration,
// reset mid-load and words_loaded saturation.
module tb_imem_ctrl;

  localparam int MEM_BYTES = 512;
  localparam int AW        = 64;
  localparam int LW        = $clog2(MEM_BYTES);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_grant;
  logic          fetch_err;
  logic [AW-1:0] im_addr;
  logic          core_hold;
  logic          ld_valid;
  logic [LW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic          ld_err;
  logic          mem_we;
  logic [LW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [9:0]    words_loaded;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  imem_ctrl #(.MEM_BYTES(MEM_BYTES), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_grant(fetch_grant),
    .fetch_err(fetch_err), .im_addr(im_addr), .core_hold(core_hold),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_err(ld_err), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .words_loaded(words_loaded)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_bytes [4];
  int         done_cnt;
  int         last_done_cyc;
  int         min_gap;
  int         max_gap;
  int         cyc;
  logic [9:0] words_at_1023;
  logic [9:0] words_at_1024;

  initial begin
    exp_bytes[0] = 8'h83; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h01; exp_bytes[3] = 8'h00;
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = 32'h0;
    tick(); tick();
    chk("rst_words", 64'(words_loaded), 64'd0);
    chk("rst_im_addr", im_addr, 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_ld_done", 64'(ld_done), 64'd0);
    chk("rst_ld_err", 64'(ld_err), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Valid load at 0x04
    ld_valid = 1'b1; ld_addr = 9'h004; ld_data = 32'h0001_0083;
    #1;
    chk("ld_hold_idle", 64'(core_hold), 64'd1);
    tick();
    ld_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wr%0d_we", k), 64'(mem_we), 64'd1);
      chk($sformatf("wr%0d_addr", k), 64'(mem_waddr), 64'(4 + k));
      chk($sformatf("wr%0d_data", k), 64'(mem_wdata), 64'(exp_bytes[k]));
      chk($sformatf("wr%0d_ready", k), 64'(ld_ready), 64'd0);
      chk($sformatf("wr%0d_hold", k), 64'(core_hold), 64'd1);
      tick();
    end
    chk("done_pulse", 64'(ld_done), 64'd1);
    chk("done_we", 64'(mem_we), 64'd0);
    chk("done_waddr", 64'(mem_waddr), 64'd0);
    chk("done_wdata", 64'(mem_wdata), 64'd0);
    chk("done_ready", 64'(ld_ready), 64'd0);
    tick();
    chk("post_done", 64'(ld_done), 64'd0);
    chk("post_ready", 64'(ld_ready), 64'd1);
    chk("post_words", 64'(words_loaded), 64'd1);

    // Misaligned load rejected
    ld_valid = 1'b1; ld_addr = 9'h006; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_valid = 1'b0;
    chk("bad_err", 64'(ld_err), 64'd1);
    chk("bad_we", 64'(mem_we), 64'd0);
    chk("bad_ready", 64'(ld_ready), 64'd1);
    tick();
    chk("bad_err_clr", 64'(ld_err), 64'd0);
    chk("bad_we2", 64'(mem_we), 64'd0);
    chk("bad_words", 64'(words_loaded), 64'd1);

    // Fetch arbitration
    fetch_req = 1'b1; fetch_addr = 64'h10;
    #1;
    chk("fe_grant", 64'(fetch_grant), 64'd1);
    chk("fe_im_addr", im_addr, 64'h10);
    chk("fe_err", 64'(fetch_err), 64'd0);
    tick();
    fetch_addr = 64'h20; ld_valid = 1'b1; ld_addr = 9'h006;
    #1;
    chk("fe_lose_grant", 64'(fetch_grant), 64'd0);
    chk("fe_lose_hold", 64'(core_hold), 64'd1);
    chk("fe_lose_im", im_addr, 64'h10);
    ld_valid = 1'b0; fetch_req = 1'b0;
    #1;
    chk("fe_idle_im", im_addr, 64'h10);
    tick();

    // Out-of-range and boundary fetches
    fetch_req = 1'b1; fetch_addr = 64'h1FC;
    #1;
    chk("fe_last_err", 64'(fetch_err), 64'd0);
    chk("fe_last_im", im_addr, 64'h1FC);
    fetch_addr = 64'h12;
    #1;
    chk("fe_misal_err", 64'(fetch_err), 64'd1);
    fetch_addr = 64'h200;
    #1;
    chk("fe_oor_err", 64'(fetch_err), 64'd1);
    chk("fe_oor_im", im_addr, 64'd0);
    tick();
    fetch_req = 1'b0;
    #1;
    chk("fe_oor_held", im_addr, 64'd0);

    // Reset in the middle of a load
    ld_valid = 1'b1; ld_addr = 9'h008; ld_data = 32'hAABB_CCDD;
    tick();
    ld_valid = 1'b0;
    chk("ra_b0_we", 64'(mem_we), 64'd1);
    chk("ra_b0_data", 64'(mem_wdata), 64'hDD);
    tick();
    chk("ra_b1_addr", 64'(mem_waddr), 64'h9);
    chk("ra_b1_data", 64'(mem_wdata), 64'hCC);
    rst_n = 1'b0;
    tick();
    chk("ra_we", 64'(mem_we), 64'd0);
    chk("ra_done", 64'(ld_done), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ra_ready", 64'(ld_ready), 64'd1);
    chk("ra_done2", 64'(ld_done), 64'd0);
    chk("ra_words", 64'(words_loaded), 64'd0);

    // Back-to-back loads at the top aligned address until saturation
    ld_valid = 1'b1; ld_addr = 9'h1FC; ld_data = 32'h1234_5678;
    done_cnt = 0; last_done_cyc = 0; min_gap = 1000; max_gap = 0;
    words_at_1023 = '0; words_at_1024 = '0;
    cyc = 0;
    while (done_cnt < 1025 && cyc < 1025 * 6 + 50) begin
      tick();
      cyc++;
      if (cyc == 4) chk("sat_top_addr", 64'(mem_waddr), 64'h1FF);
      if (ld_done) begin
        done_cnt++;
        if (done_cnt > 1) begin
          if (cyc - last_done_cyc < min_gap) min_gap = cyc - last_done_cyc;
          if (cyc - last_done_cyc > max_gap) max_gap = cyc - last_done_cyc;
        end
        last_done_cyc = cyc;
        if (done_cnt == 1023) words_at_1023 = words_loaded;
        if (done_cnt == 1024) words_at_1024 = words_loaded;
      end
    end
    ld_valid = 1'b0;
    chk("sat_loads", 64'(done_cnt), 64'd1025);
    chk("sat_min_gap", 64'(min_gap), 64'd6);
    chk("sat_max_gap", 64'(max_gap), 64'd6);
    chk("sat_pre", 64'(words_at_1023), 64'd1022);
    chk("sat_reach", 64'(words_at_1024), 64'd1023);
    tick();
    chk("sat_final", 64'(words_loaded), 64'd1023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
